// File: rtl/xor_parity_serializer.sv
// Parity-protected serialiser: shifts a parallel word out LSB first, then
// appends the running XOR of its bits (inverted when PARITY_ODD is set).
module xor_parity_serializer #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic             acc;
  logic [CW-1:0]    cnt;
  logic             can_accept;
  logic             accept;

  // Acceptance depends only on registered state; din_valid merely qualifies it.
  always_comb begin
    can_accept = (state == IDLE) || (state == PARITY);
    accept     = din_valid && can_accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = DATA;
      DATA:    if (cnt == CNT_LAST) state_nx = PARITY;
      PARITY:  state_nx = accept ? DATA : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      acc   <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= din;
      acc   <= PARITY_ODD;
      cnt   <= '0;
    end else if (state == DATA) begin
      acc   <= acc ^ shreg[0];
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // rst gates the outputs so din_ready stays low for the whole reset pulse.
  always_comb begin
    din_ready  = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          din_ready = 1'b1;
        end
        DATA: begin
          sout       = shreg[0];
          sout_valid = 1'b1;
        end
        PARITY: begin
          sout       = acc;
          sout_valid = 1'b1;
          sout_last  = 1'b1;
          din_ready  = 1'b1;
        end
        default: begin
          din_ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_parity_serializer.sv
// Directed bench for xor_parity_serializer: even/odd parity, WIDTH=1,
// back-to-back frames, busy-time requests and asynchronous reset.
module tb_xor_parity_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] e_din, o_din;
  logic       e_v, o_v;
  logic       e_ready, e_sout, e_valid, e_last;
  logic       o_ready, o_sout, o_valid, o_last;
  logic [0:0] w_din;
  logic       w_v;
  logic       w_ready, w_sout, w_valid, w_last;

  int checks   = 0;
  int failures = 0;

  xor_parity_serializer #(.WIDTH(8), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .din(e_din), .din_valid(e_v), .din_ready(e_ready),
    .sout(e_sout), .sout_valid(e_valid), .sout_last(e_last)
  );

  xor_parity_serializer #(.WIDTH(8), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .din(o_din), .din_valid(o_v), .din_ready(o_ready),
    .sout(o_sout), .sout_valid(o_valid), .sout_last(o_last)
  );

  xor_parity_serializer #(.WIDTH(1), .PARITY_ODD(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .din(w_din), .din_valid(w_v), .din_ready(w_ready),
    .sout(w_sout), .sout_valid(w_valid), .sout_last(w_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {sout, sout_valid, sout_last, din_ready} of the selected 8-bit instance
  function automatic logic [3:0] outs(input int s);
    if (s == 0) return {e_sout, e_valid, e_last, e_ready};
    return {o_sout, o_valid, o_last, o_ready};
  endfunction

  task automatic drive(input int s, input logic [7:0] w, input logic v);
    if (s == 0) begin
      e_din = w;
      e_v   = v;
    end else begin
      o_din = w;
      o_v   = v;
    end
  endtask

  task automatic send_frame(input int s, input logic [7:0] w, input logic p, input string tag);
    logic [3:0] o;
    o = outs(s);
    check({tag, "_idle_ready"}, 32'(o[0]), 32'd1);
    drive(s, w, 1'b1);
    tick();
    drive(s, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      o = outs(s);
      check($sformatf("%s_bit%0d", tag, i), {28'd0, o}, {28'd0, w[i], 1'b1, 1'b0, 1'b0});
      tick();
    end
    o = outs(s);
    check({tag, "_parity"}, {28'd0, o}, {28'd0, p, 1'b1, 1'b1, 1'b1});
    tick();
    o = outs(s);
    check({tag, "_after"}, {28'd0, o}, {28'd0, 4'b0001});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b2b [2];
    logic       b2b_par [2];
    int         vcount;

    rst   = 1'b1;
    e_din = 8'h00; e_v = 1'b0;
    o_din = 8'h00; o_v = 1'b0;
    w_din = 1'b1;  w_v = 1'b1;   // held valid across reset release
    #1;
    check("rst_outs", {28'd0, e_sout, e_valid, e_last, e_ready}, 32'd0);
    check("rst_w1_ready", 32'(w_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rel_ready", 32'(e_ready), 32'd1);
    check("rel_w1", {30'd0, w_valid, w_ready}, 32'b01);

    // WIDTH=1: accepted on first edge after release, one DATA then one PARITY cycle
    tick();
    check("w1_data", {28'd0, w_sout, w_valid, w_last, w_ready}, 32'b1100);
    w_v = 1'b0;
    tick();
    check("w1_parity", {28'd0, w_sout, w_valid, w_last, w_ready}, 32'b1111);
    tick();
    check("w1_idle", {28'd0, w_sout, w_valid, w_last, w_ready}, 32'b0001);

    send_frame(0, 8'hA5, 1'b0, "even_a5");
    send_frame(0, 8'h07, 1'b1, "even_07");
    send_frame(1, 8'h00, 1'b1, "odd_00");
    send_frame(1, 8'hFF, 1'b1, "odd_ff");

    // Back-to-back with din_valid held high
    b2b[0] = 8'h01; b2b_par[0] = 1'b1;
    b2b[1] = 8'h03; b2b_par[1] = 1'b0;
    vcount = 0;
    check("b2b_idle_ready", 32'(e_ready), 32'd1);
    e_din = b2b[0]; e_v = 1'b1;
    tick();
    e_din = b2b[1];
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 9; i++) begin
        if (e_valid) vcount++;
        if (i < 8)
          check($sformatf("b2b_f%0d_bit%0d", f, i), {28'd0, e_sout, e_valid, e_last, e_ready},
                {28'd0, b2b[f][i], 3'b100});
        else begin
          check($sformatf("b2b_f%0d_parity", f), {28'd0, e_sout, e_valid, e_last, e_ready},
                {28'd0, b2b_par[f], 3'b111});
          if (f == 1) e_v = 1'b0;
        end
        tick();
      end
    end
    check("b2b_valid_cycles", 32'(vcount), 32'd18);
    check("b2b_after", {28'd0, e_sout, e_valid, e_last, e_ready}, 32'b0001);

    // Requests during DATA are ignored; held request taken on PARITY edge
    e_din = 8'h01; e_v = 1'b1;
    tick();
    e_din = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("busy_01_bit%0d", i), {28'd0, e_sout, e_valid, e_last, e_ready},
            {28'd0, (i == 0), 3'b100});
      tick();
    end
    check("busy_01_parity", {28'd0, e_sout, e_valid, e_last, e_ready}, 32'b1111);
    tick();
    e_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("busy_ff_bit%0d", i), {28'd0, e_sout, e_valid, e_last, e_ready}, 32'b1100);
      tick();
    end
    check("busy_ff_parity", {28'd0, e_sout, e_valid, e_last, e_ready}, 32'b0111);
    tick();
    check("busy_after", {28'd0, e_sout, e_valid, e_last, e_ready}, 32'b0001);

    // Asynchronous reset in the middle of frame A5 (bit 3 on the line)
    e_din = 8'hA5; e_v = 1'b1;
    tick();
    e_v = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("mid_bit3", {28'd0, e_sout, e_valid, e_last, e_ready}, 32'b0100);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outs", {28'd0, e_sout, e_valid, e_last, e_ready}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rel", {28'd0, e_sout, e_valid, e_last, e_ready}, 32'b0001);
    send_frame(0, 8'h80, 1'b1, "post_rst_80");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_parity_serializer.md
# xor_parity_serializer

- Serialises a parallel data word one bit per clock, LSB first, and appends a parity bit.
- The parity bit is the running XOR of every data bit in the word, optionally inverted for odd parity.
- Sits directly downstream of the team's XOR primitives: it is the sequential XOR-chain stage that consumes a word and produces a parity-protected serial stream for a line driver or a serial parity checker.

## Interface
Parameters:
- WIDTH, 8: data word width in bits; legal range WIDTH >= 1.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel data word.
- din_valid  input  1  din holds a word to transmit.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit (data bits LSB first, then parity).
- sout_valid  output  1  sout carries a frame bit this cycle.
- sout_last  output  1  current sout bit is the parity bit (last bit of the frame).

## Operation
- One clock; reset is asynchronous and active-high.
- Registers:
  - state: IDLE, DATA or PARITY.
  - shreg: WIDTH bits.
  - acc: running parity, 1 bit.
  - cnt: $clog2(WIDTH+1) bits.
- Reset:
  - state=IDLE, shreg=0, acc=0, cnt=0.
  - While rst is high: din_ready=0, sout=0, sout_valid=0, sout_last=0.
- Accept: a word is taken on a rising edge where din_valid && din_ready. On that edge:
  - shreg <= din
  - acc <= PARITY_ODD
  - cnt <= 0
  - state <= DATA
- IDLE:
  - din_ready=1, sout_valid=0, sout=0, sout_last=0.
  - Without an accept, the block stays in IDLE.
- DATA:
  - Outputs: sout=shreg[0], sout_valid=1, sout_last=0, din_ready=0.
  - On each edge: acc <= acc ^ shreg[0]; shreg <= shreg >> 1 (zero fill); cnt <= cnt+1.
  - When cnt==WIDTH-1 on an edge, state <= PARITY.
- PARITY:
  - Outputs: sout=acc, sout_valid=1, sout_last=1, din_ready=1.
  - On the next edge: an accept goes straight to DATA (back-to-back frames); otherwise state <= IDLE.
- Parity value: the parity bit equals the XOR-reduction of the accepted word, XOR PARITY_ODD.
- Words are captured only at accept. din is otherwise don't-care.
- din_valid while din_ready=0 is ignored. Upstream must hold din/din_valid until accepted.
- All outputs are decoded from registered state only. There is no combinational path from din or din_valid to any output.

## Timing
- Latency: the accept edge is edge k.
  - Data bit i is presented in the cycle after edge k+i, for i = 0..WIDTH-1.
  - The parity bit is presented in the cycle after edge k+WIDTH.
- Frame length: exactly WIDTH+1 consecutive sout_valid cycles. sout_last is high only on the final one.
- Throughput:
  - With din_valid held high, the block accepts one word every WIDTH+1 cycles.
  - No idle gap between frames; sout_valid stays continuously high.
- WIDTH=1: one DATA cycle, then one PARITY cycle.
- Reset mid-frame:
  - Outputs drop to reset values immediately, without waiting for a clock edge.
  - The partial frame is discarded.
  - After rst deasserts, the block is in IDLE with din_ready=1 in the same cycle.
- rst deasserted with din_valid already high: the first accept occurs on the first rising edge after deassertion.

## Test plan
- Even parity, din=8'hA5, single accept:
  - sout sequence 1,0,1,0,0,1,0,1, then parity 0 with sout_last=1.
  - Then IDLE, sout_valid=0.
- Even parity, din=8'h07: data bits 1,1,1,0,0,0,0,0, then parity 1.
- PARITY_ODD=1: din=8'h00 gives parity 1; din=8'hFF gives parity 1.
- Back-to-back: din_valid held high with words 8'h01 then 8'h03.
  - 18 consecutive sout_valid cycles.
  - Parities 1 then 0.
  - din_ready high only in the two PARITY cycles and the initial IDLE cycle.
- Ignore while busy: din_valid pulsed with 8'hFF during the DATA cycles of frame 8'h01.
  - Frame 8'h01 is unaffected.
  - 8'hFF is accepted only on the PARITY-cycle edge, if din_valid is still held.
- Async reset: rst asserted between edges at bit 3 of frame 8'hA5.
  - sout_valid=0 and din_ready=0 immediately.
  - After release, a new word 8'h80 serialises cleanly: 0,0,0,0,0,0,0,1, then parity 1.
